// File: rtl/cq_viola_nios2_e_oci_pkg.sv
// Shared definitions for the Nios II OCI debug-RAM controller:
// jdo field positions, datapath width and the JTAG access sequencer states.
package cq_viola_nios2_e_oci_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned JDO_W         = 38;
  localparam int unsigned JDO_RD_BIT    = 35;
  localparam int unsigned JDO_ADDR_LSB  = 26;
  localparam int unsigned JDO_WDATA_MSB = 34;
  localparam int unsigned JDO_WDATA_LSB = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_WAIT,
    ST_WR
  } ocimem_state_e;

  // One-hot view of the strobe that wins same-cycle arbitration (b > a > no_action).
  typedef struct packed {
    logic b;
    logic a;
    logic na;
  } ocimem_cmd_t;

  function automatic ocimem_cmd_t pick_cmd(input logic b, input logic a, input logic na);
    ocimem_cmd_t c;
    c.b  = b;
    c.a  = a & ~b;
    c.na = na & ~a & ~b;
    return c;
  endfunction

endpackage

// File: rtl/cq_viola_nios2_e_ocimem_ram.sv
// Single-port synchronous debug RAM, 32-bit words, one-cycle read latency.
// Contents are never reset; an optional init file is attached as a RAM attribute.
module cq_viola_nios2_e_ocimem_ram
  import cq_viola_nios2_e_oci_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter              INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  // Two copies only so the init-file attribute is present solely when a file is given.
  if (INIT_FILE != "") begin : g_init
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
    end
  end else begin : g_noinit
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_o <= mem_q[addr_i];
    end
  end

endmodule

// File: rtl/cq_viola_nios2_e_jtag_ocimem_ctrl.sv
// Turns the JTAG wrapper's ocimem strobes into debug-RAM accesses and shares
// the same single-port RAM with the CPU Avalon-MM slave (JTAG has priority).
module cq_viola_nios2_e_jtag_ocimem_ctrl
  import cq_viola_nios2_e_oci_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter              INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_readdatavalid,
  output logic              avs_waitrequest
);

  ocimem_state_e state_q, state_d;

  logic [ADDR_W-1:0] mon_addr_q, mon_addr_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              ready_q,    ready_d;
  logic              error_q,    error_d;
  logic              rvalid_q,   rvalid_d;

  logic              idle;
  logic              any_strobe;
  ocimem_cmd_t       cmd;
  logic              acc_a, acc_b, acc_na, drop;
  logic              cpu_rd_acc, cpu_wr_acc;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  logic              jdo_unused;
  assign jdo_unused = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0]};

  assign idle       = (state_q == ST_IDLE);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign cmd        = pick_cmd(take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a);
  assign acc_b      = idle & cmd.b;
  assign acc_a      = idle & cmd.a;
  assign acc_na     = idle & cmd.na;
  assign drop       = ~idle & any_strobe;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (acc_b) begin
          state_d = ST_WR;
        end else if ((acc_a & jdo[JDO_RD_BIT]) | acc_na) begin
          state_d = ST_RD;
        end
      end
      ST_RD:      state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = ST_IDLE;
      ST_WR:      state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output logic: RAM port mux and CPU handshake
  always_comb begin
    avs_waitrequest = ~idle | any_strobe;
    cpu_wr_acc      = avs_write & ~avs_waitrequest;
    cpu_rd_acc      = avs_read & ~avs_write & ~avs_waitrequest;
    ram_addr        = avs_address;
    ram_we          = cpu_wr_acc;
    ram_wdata       = avs_writedata;
    unique case (state_q)
      ST_RD: begin
        ram_addr = mon_addr_q;
        ram_we   = 1'b0;
      end
      ST_WR: begin
        ram_addr  = mon_addr_q;
        ram_we    = 1'b1;
        ram_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  // Monitor register updates; strobe acceptance only happens in IDLE,
  // completion only in RD_WAIT/WR, so the two groups never collide.
  always_comb begin
    mon_addr_d = mon_addr_q;
    mon_dreg_d = mon_dreg_q;
    wdata_d    = wdata_q;
    ready_d    = ready_q;
    error_d    = error_q;
    rvalid_d   = cpu_rd_acc;

    if (acc_b) begin
      wdata_d = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
      ready_d = 1'b0;
    end else if (acc_a) begin
      mon_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
      error_d    = 1'b0;
      ready_d    = ~jdo[JDO_RD_BIT];
    end else if (acc_na) begin
      ready_d = 1'b0;
    end

    if (drop) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      ST_RD_WAIT: begin
        mon_dreg_d = ram_rdata;
        mon_addr_d = mon_addr_q + 1'b1;
        ready_d    = 1'b1;
      end
      ST_WR: begin
        mon_addr_d = mon_addr_q + 1'b1;
        ready_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mon_addr_q <= '0;
      mon_dreg_q <= '0;
      wdata_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      mon_addr_q <= mon_addr_d;
      mon_dreg_q <= mon_dreg_d;
      wdata_q    <= wdata_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      rvalid_q   <= rvalid_d;
    end
  end

  cq_viola_nios2_e_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i   (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign MonDReg           = mon_dreg_q;
  assign monitor_ready     = ready_q;
  assign monitor_error     = error_q;
  assign avs_readdatavalid = rvalid_q;
  assign avs_readdata      = rvalid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_cq_viola_nios2_e_jtag_ocimem_ctrl.sv
// Randomised self-checking bench for the OCI debug-RAM controller, with a
// transaction-level reference model and directed literal scenarios.
module tb_cq_viola_nios2_e_jtag_ocimem_ctrl;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [37:0]   jdo = '0;
  logic          take_a = 1'b0, take_b = 1'b0, take_na = 1'b0;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;
  logic [AW-1:0] avs_address = '0;
  logic          avs_read = 1'b0, avs_write = 1'b0;
  logic [31:0]   avs_writedata = '0;
  logic [31:0]   avs_readdata;
  logic          avs_readdatavalid, avs_waitrequest;

  always #5 clk = ~clk;

  cq_viola_nios2_e_jtag_ocimem_ctrl #(
    .ADDR_W    (AW),
    .INIT_FILE ("")
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_readdatavalid       (avs_readdatavalid),
    .avs_waitrequest         (avs_waitrequest)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference model: a JTAG op is "busy" for a fixed number of cycles after
  // the accepting edge and lands its result when that window closes.
  logic [31:0] mem [256];
  bit   [7:0]  m_addr;
  logic [31:0] m_dreg, m_wd, m_rdata;
  bit          m_ready, m_err, m_rvalid, m_is_wr;
  int          m_left;
  bit          m_busy, m_stb;
  bit          chk_en = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_addr = '0; m_dreg = '0; m_ready = 0; m_err = 0; m_rvalid = 0; m_left = 0;
    end else begin
      m_busy   = (m_left != 0);
      m_stb    = take_a | take_b | take_na;
      m_rvalid = 0;
      if (!m_busy && !m_stb) begin
        if (avs_write) mem[avs_address] = avs_writedata;
        else if (avs_read) begin
          m_rvalid = 1;
          m_rdata  = mem[avs_address];
        end
      end
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          if (m_is_wr) mem[m_addr] = m_wd;
          else         m_dreg = mem[m_addr];
          m_addr++;
          m_ready = 1;
        end
        if (m_stb) m_err = 1;
      end else if (m_stb) begin
        if (take_b) begin
          m_wd = jdo[34:3]; m_is_wr = 1; m_left = 1; m_ready = 0;
        end else if (take_a) begin
          m_addr = jdo[33:26];
          m_err  = 0;
          if (jdo[35]) begin m_is_wr = 0; m_left = 2; m_ready = 0; end
          else m_ready = 1;
        end else begin
          m_is_wr = 0; m_left = 2; m_ready = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("waitrequest", {31'b0, avs_waitrequest}, {31'b0, (m_left != 0) | take_a | take_b | take_na});
      chk("MonDReg", MonDReg, m_dreg);
      chk("monitor_ready", {31'b0, monitor_ready}, {31'b0, m_ready});
      chk("monitor_error", {31'b0, monitor_error}, {31'b0, m_err});
      chk("readdatavalid", {31'b0, avs_readdatavalid}, {31'b0, m_rvalid});
      if (m_rvalid) chk("readdata", avs_readdata, m_rdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rd);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[33:26] = addr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  task automatic strobe_a(input logic [7:0] addr, input logic rd);
    jdo = jdo_a(addr, rd); take_a = 1; tick(); take_a = 0;
  endtask

  initial begin
    logic [63:0] r;
    repeat (3) tick();
    reset = 0;
    tick();
    @(negedge clk);
    chk("reset MonDReg", MonDReg, 32'h0);
    chk("reset ready", {31'b0, monitor_ready}, 32'h0);
    chk("reset error", {31'b0, monitor_error}, 32'h0);
    chk("reset waitrequest", {31'b0, avs_waitrequest}, 32'h0);
    chk_en = 1;

    // Fill every RAM word from the CPU side
    tick();
    for (int i = 0; i < 256; i++) begin
      avs_write = 1; avs_address = 8'(i);
      avs_writedata = (i == 255) ? 32'hFFFF_0001 : (i == 0) ? 32'hA5A5_0000 : $urandom;
      tick();
    end
    avs_write = 0;
    tick();

    // JTAG write of DEADBEEF to 0x10, CPU readback, JTAG readback
    strobe_a(8'h10, 1'b0);
    @(negedge clk); chk("addr-only ready", {31'b0, monitor_ready}, 32'h1);
    tick();
    jdo = jdo_b(32'hDEAD_BEEF); take_b = 1; tick(); take_b = 0;
    @(negedge clk); chk("wr ready +1", {31'b0, monitor_ready}, 32'h0);
    tick();
    @(negedge clk); chk("wr ready +2", {31'b0, monitor_ready}, 32'h1);
    tick();
    avs_read = 1; avs_address = 8'h10; tick(); avs_read = 0;
    @(negedge clk);
    chk("cpu rd valid", {31'b0, avs_readdatavalid}, 32'h1);
    chk("cpu rd 0x10", avs_readdata, 32'hDEAD_BEEF);
    tick();
    strobe_a(8'h10, 1'b1);
    tick();
    @(negedge clk); chk("rd ready +2", {31'b0, monitor_ready}, 32'h0);
    tick();
    @(negedge clk);
    chk("rd ready +3", {31'b0, monitor_ready}, 32'h1);
    chk("rd MonDReg", MonDReg, 32'hDEAD_BEEF);
    tick();

    // Auto-increment wrap 0xFF -> 0x00
    strobe_a(8'hFF, 1'b0);
    take_na = 1; tick(); take_na = 0; tick(); tick();
    @(negedge clk); chk("rd 0xFF", MonDReg, 32'hFFFF_0001);
    tick();
    take_na = 1; tick(); take_na = 0; tick(); tick();
    @(negedge clk); chk("rd wrap 0x00", MonDReg, 32'hA5A5_0000);
    tick();

    // Busy collision: a during WR is dropped and flags an error
    strobe_a(8'h20, 1'b0);
    jdo = jdo_b(32'h1111_1111); take_b = 1; tick(); take_b = 0;
    strobe_a(8'h30, 1'b0);
    @(negedge clk);
    chk("collision error", {31'b0, monitor_error}, 32'h1);
    chk("collision ready", {31'b0, monitor_ready}, 32'h1);
    tick();
    avs_read = 1; avs_address = 8'h20; tick(); avs_read = 0;
    @(negedge clk); chk("collision wr data", avs_readdata, 32'h1111_1111);
    tick();
    strobe_a(8'h40, 1'b0);
    @(negedge clk); chk("error cleared", {31'b0, monitor_error}, 32'h0);
    tick();

    // Arbitration: CPU read stalls behind a JTAG write to the same word
    avs_read = 1; avs_address = 8'h40;
    jdo = jdo_b(32'hCAFE_F00D); take_b = 1;
    @(negedge clk); chk("arb wait c0", {31'b0, avs_waitrequest}, 32'h1);
    tick(); take_b = 0;
    @(negedge clk); chk("arb wait c1", {31'b0, avs_waitrequest}, 32'h1);
    tick();
    @(negedge clk); chk("arb wait c2", {31'b0, avs_waitrequest}, 32'h0);
    tick(); avs_read = 0;
    @(negedge clk); chk("arb readdata", avs_readdata, 32'hCAFE_F00D);
    tick();

    // Asynchronous reset during RD_WAIT
    strobe_a(8'h10, 1'b1);
    tick();
    #2 reset = 1;
    #1;
    chk("async MonDReg", MonDReg, 32'h0);
    chk("async waitrequest", {31'b0, avs_waitrequest}, 32'h0);
    chk("async ready", {31'b0, monitor_ready}, 32'h0);
    reset = 0;
    tick();
    @(negedge clk);
    chk("post-reset MonDReg", MonDReg, 32'h0);
    chk("post-reset waitrequest", {31'b0, avs_waitrequest}, 32'h0);
    tick();

    // Random traffic on both ports
    for (int n = 0; n < 3000; n++) begin
      r = {$urandom, $urandom};
      jdo           = r[37:0];
      take_a        = ($urandom_range(0, 99) < 8);
      take_b        = ($urandom_range(0, 99) < 8);
      take_na       = ($urandom_range(0, 99) < 8);
      avs_read      = ($urandom_range(0, 99) < 30);
      avs_write     = ($urandom_range(0, 99) < 25);
      avs_address   = 8'($urandom);
      avs_writedata = $urandom;
      tick();
    end
    take_a = 0; take_b = 0; take_na = 0; avs_read = 0; avs_write = 0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cq_viola_nios2_e_jtag_ocimem_ctrl.md
Name: cq_viola_nios2_e_jtag_ocimem_ctrl

Overview:
Downstream consumer of the JTAG debug module wrapper's sysclk-domain outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a). Decodes those strobes into read/write accesses on the on-chip debug RAM and returns MonDReg, monitor_ready and monitor_error to the wrapper. Also arbitrates the CPU-side Avalon-MM slave port onto the same single-port RAM, with JTAG taking priority.

Parameters:
ADDR_W, 8, debug RAM word-address width (depth 2^ADDR_W words of 32 bits)
INIT_FILE, "", RAM initialisation file passed to sub-module; empty = uninitialised

Ports:
clk  in  1  system clock (same clk as wrapper sysclk half)
reset  in  1  asynchronous, active-high reset
jdo  in  38  captured JTAG data from wrapper
take_action_ocimem_a  in  1  address/command strobe, 1 cycle
take_action_ocimem_b  in  1  write-data strobe, 1 cycle
take_no_action_ocimem_a  in  1  read-next strobe, 1 cycle
MonDReg  out  32  monitor data register to wrapper
monitor_ready  out  1  last JTAG access complete
monitor_error  out  1  strobe dropped while busy
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_readdata  out  32  CPU read data
avs_readdatavalid  out  1  readdata qualifier
avs_waitrequest  out  1  CPU stall

Behaviour:
- Reset: MonDReg=0, internal MonAReg=0, monitor_ready=0, monitor_error=0, avs_readdatavalid=0, FSM=IDLE. RAM contents are not reset.
- The clock is clk; reset is asynchronous and active-high on port reset, and is applied to every register listed above.
- jdo decode:
  - take_action_ocimem_a: MonAReg<=jdo[26+ADDR_W-1:26]; if jdo[35]=1, start a read; else no RAM access, monitor_ready<=1 next edge.
  - take_action_ocimem_b: write jdo[34:3] to MonAReg.
  - take_no_action_ocimem_a: read at current MonAReg.
- Same-cycle strobe priority: b > a > no_action. Losers are dropped silently.
- FSM states: IDLE, RD, RD_WAIT, WR.
  - IDLE, accepted read (strobe at edge E0): monitor_ready<=0, ->RD.
  - RD: RAM addr=MonAReg, read enable; ->RD_WAIT.
  - RD_WAIT: RAM q valid; at edge MonDReg<=q, MonAReg<=MonAReg+1, monitor_ready<=1, ->IDLE. monitor_ready is first high in the 3rd cycle after the strobe cycle.
  - IDLE, accepted write: capture data, monitor_ready<=0, ->WR.
  - WR: RAM we=1; at edge MonAReg+1, monitor_ready<=1, ->IDLE. 2-cycle latency.
- MonAReg increments modulo 2^ADDR_W; 2^ADDR_W-1 wraps to 0.
- Strobe while FSM not IDLE: strobe ignored, monitor_error<=1. monitor_error clears on the next accepted take_action_ocimem_a.
- CPU port:
  - avs_waitrequest = (FSM!=IDLE) | any ocimem strobe this cycle.
  - Read accepted when avs_read & !avs_waitrequest: RAM read that cycle; avs_readdatavalid=1 with avs_readdata on the following cycle only.
  - Write accepted likewise, written in the same cycle.
  - avs_read and avs_write together: write wins, no readdatavalid.
- CPU accesses never alter MonAReg, MonDReg or monitor_*.
- Reset mid-operation: FSM->IDLE, pending RAM write abandoned, outputs to reset values.

Decomposition:
- Package cq_viola_nios2_e_oci_pkg holds:
  - jdo field constants: JDO_RD_BIT=35, JDO_ADDR_LSB=26, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3.
  - FSM state enum.
  - Data width constant 32.
- One sub-module: cq_viola_nios2_e_ocimem_ram.
  - Single-port synchronous RAM, 1-cycle read latency, byte enables not required.
  - Parameters ADDR_W and INIT_FILE.
  - Top-level mux selects the JTAG or CPU address/we/wdata.

Test Plan:
- Reset released, no stimulus -> MonDReg=0, monitor_ready=0, monitor_error=0, avs_waitrequest=0.
- Write 0xDEADBEEF: strobe a with jdo addr=0x10, jdo[35]=0; then strobe b with data 0xDEADBEEF -> monitor_ready high 2 cycles after b. CPU then reads 0x10 -> readdata 0xDEADBEEF. JTAG read from addr 0x10 with jdo[35]=1 -> MonDReg=0xDEADBEEF 3 cycles after the strobe.
- Auto-increment and wrap: MonAReg=0xFF (ADDR_W=8), two take_no_action_ocimem_a strobes 4 cycles apart -> reads of addr 0xFF then 0x00.
- Busy collision: strobe b, then strobe a on the next cycle -> second strobe ignored, monitor_error=1, RAM written once. monitor_error clears on the next accepted a.
- Arbitration: avs_read and strobe b asserted in the same cycle -> avs_waitrequest=1 for 2 cycles. CPU read accepted afterwards and returns the newly written value.
- Async reset asserted during RD_WAIT -> outputs reset immediately without waiting for a clock edge; FSM in IDLE after release; MonDReg=0.
